// File: rtl/decode_pkg.sv
// decode_pkg: ALU encodings, MIPS opcode/function constants and the decoded-entry record
package decode_pkg;
  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000, ALU_OR   = 4'b0001, ALU_XOR  = 4'b0010, ALU_CMPZ  = 4'b0011,
    ALU_LEZ   = 4'b0100, ALU_SLL  = 4'b0101, ALU_SRA  = 4'b0110, ALU_SRL   = 4'b0111,
    ALU_SLT   = 4'b1000, ALU_SLTU = 4'b1001, ALU_ADDU = 4'b1010, ALU_SUBU  = 4'b1011,
    ALU_DIV   = 4'b1100, ALU_DIVU = 4'b1101, ALU_MULT = 4'b1110, ALU_MULTU = 4'b1111
  } alu_op_e;
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR = 6'h08, FN_JALR = 6'h09;
  localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13;
  localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1A, FN_DIVU = 6'h1B;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;
  typedef struct packed {
    alu_op_e     alu_op;
    logic        reg_wr_en, mem_wr_en, use_alu, pc_branch, pc_jump, i_type, j_type, r_type, illegal;
    logic [4:0]  rs, rt, dest, shamt;
    logic [31:0] imm;
  } decoded_t;
endpackage

// File: rtl/decode_fields.sv
// decode_fields: combinational decode of one instruction word into a decoded entry
module decode_fields
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec,
  output logic        muldiv,
  output logic        hilo_use
);
  logic [5:0] op, fn;
  logic r_type, j_type, ok, store, branch, no_wr;
  alu_op_e alu;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign r_type = op == OP_SPECIAL;
  assign j_type = op[5:1] == 5'b00001;
  assign muldiv = r_type & (fn[5:2] == 4'b0110);
  assign hilo_use = muldiv | (r_type & (fn[5:2] == 4'b0100));
  assign store = op[5:3] == 3'b101;
  assign branch = (op == OP_REGIMM) | (op[5:2] == 4'b0001);
  assign no_wr = muldiv | (r_type & (fn == FN_MTHI | fn == FN_MTLO | fn == FN_JR)) | store | branch | (op == OP_J);
  // opcode / function tables: ALU operation and legality
  always_comb begin
    alu = ALU_AND;
    ok = 1'b1;
    case (op)
      OP_SPECIAL:
        case (fn)
          FN_SLL, FN_SLLV: alu = ALU_SLL;
          FN_SRL, FN_SRLV: alu = ALU_SRL;
          FN_SRA, FN_SRAV: alu = ALU_SRA;
          FN_MULT:         alu = ALU_MULT;
          FN_MULTU:        alu = ALU_MULTU;
          FN_DIV:          alu = ALU_DIV;
          FN_DIVU:         alu = ALU_DIVU;
          FN_ADDU:         alu = ALU_ADDU;
          FN_SUBU:         alu = ALU_SUBU;
          FN_AND:          alu = ALU_AND;
          FN_OR:           alu = ALU_OR;
          FN_XOR:          alu = ALU_XOR;
          FN_SLT:          alu = ALU_SLT;
          FN_SLTU:         alu = ALU_SLTU;
          FN_JR, FN_JALR, FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO: alu = ALU_AND;
          default:         ok = 1'b0;
        endcase
      OP_REGIMM: begin
        alu = ALU_CMPZ;
        ok = instr[19:17] == 3'b000;
      end
      OP_BEQ, OP_BNE:   alu = ALU_XOR;
      OP_BLEZ, OP_BGTZ: alu = ALU_LEZ;
      OP_ADDIU:         alu = ALU_ADDU;
      OP_SLTI:          alu = ALU_SLT;
      OP_SLTIU:         alu = ALU_SLTU;
      OP_ANDI:          alu = ALU_AND;
      OP_ORI:           alu = ALU_OR;
      OP_XORI:          alu = ALU_XOR;
      OP_J, OP_JAL, OP_LUI, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: alu = ALU_AND;
      default:          ok = 1'b0;
    endcase
  end
  // assemble the entry; illegal words still flow but never write state
  always_comb begin
    dec.alu_op = alu;
    dec.reg_wr_en = ok & ~no_wr;
    dec.mem_wr_en = ok & store;
    dec.use_alu = ~op[0];
    dec.pc_branch = branch;
    dec.pc_jump = (r_type & (fn[5:1] == 5'b00100)) | j_type;
    dec.i_type = ~r_type & ~j_type;
    dec.j_type = j_type;
    dec.r_type = r_type;
    dec.illegal = ~ok;
    dec.rs = instr[25:21];
    dec.rt = instr[20:16];
    dec.dest = r_type ? instr[15:11] : ((op == OP_JAL) | ((op == OP_REGIMM) & instr[20])) ? 5'd31 : instr[20:16];
    dec.shamt = instr[10:6];
    dec.imm = (op == OP_LUI) ? {instr[15:0], 16'h0000} :
              (op == OP_ANDI | op == OP_ORI | op == OP_XORI) ? {16'h0000, instr[15:0]} :
              {{16{instr[15]}}, instr[15:0]};
  end
endmodule

// File: rtl/instruction_decode_pipe.sv
// instruction_decode_pipe: decode stage feeding a small FIFO, with HI/LO hazard stall and flush
module instruction_decode_pipe
  import decode_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int MULDIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_op,
  output logic        reg_wr_en,
  output logic        mem_wr_en,
  output logic        use_alu,
  output logic        pc_branch,
  output logic        pc_jump,
  output logic        i_type,
  output logic        j_type,
  output logic        r_type,
  output logic        illegal,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  dest,
  output logic [4:0]  shamt,
  output logic [31:0] imm,
  output logic        hilo_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MULDIV_CYCLES + 1);
  decoded_t in_dec, head;
  decoded_t mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [CW-1:0] busy_q, busy_d;
  logic muldiv, hilo_use, full, stall, push, pop;
  decode_fields u_dec (.instr(instr), .dec(in_dec), .muldiv(muldiv), .hilo_use(hilo_use));
  assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign hilo_busy = busy_q != '0;
  assign stall = hilo_busy & hilo_use;
  assign in_ready = ~full & ~flush & ~stall;
  assign out_valid = cnt_q != '0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready & ~flush;
  // pointer/count/busy next state; flush wins over push and pop, busy keeps counting
  always_comb begin
    wptr_d = flush ? '0 : wptr_q + AW'(push);
    rptr_d = flush ? '0 : rptr_q + AW'(pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    busy_d = (push & muldiv) ? CW'(MULDIV_CYCLES) : busy_q - CW'(hilo_busy);
  end
  // control state with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      busy_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
    end
  end
  // entry storage needs no reset; validity is tracked by the count
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_dec;
  end
  assign head = mem_q[rptr_q];
  assign alu_op = head.alu_op;
  assign reg_wr_en = head.reg_wr_en;
  assign mem_wr_en = head.mem_wr_en;
  assign use_alu = head.use_alu;
  assign pc_branch = head.pc_branch;
  assign pc_jump = head.pc_jump;
  assign i_type = head.i_type;
  assign j_type = head.j_type;
  assign r_type = head.r_type;
  assign illegal = head.illegal;
  assign rs = head.rs;
  assign rt = head.rt;
  assign dest = head.dest;
  assign shamt = head.shamt;
  assign imm = head.imm;
endmodule

// File: tb/tb_instruction_decode_pipe.sv
// tb_instruction_decode_pipe: directed scoreboard bench for the decode pipe
module tb_instruction_decode_pipe;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic in_ready, out_valid, reg_wr_en, mem_wr_en, use_alu, pc_branch, pc_jump, i_type, j_type, r_type, illegal, hilo_busy;
  logic [3:0] alu_op;
  logic [4:0] rs, rt, dest, shamt;
  logic [31:0] imm;
  logic [64:0] sig, cur_exp;
  string cur_tag;
  int n_vec = 0, n_err = 0, waited;
  typedef struct { logic [64:0] e; string tag; } ent_t;
  ent_t q[$];
  ent_t ent;

  instruction_decode_pipe #(.FIFO_DEPTH(4), .MULDIV_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op), .reg_wr_en(reg_wr_en), .mem_wr_en(mem_wr_en),
    .use_alu(use_alu), .pc_branch(pc_branch), .pc_jump(pc_jump), .i_type(i_type), .j_type(j_type), .r_type(r_type),
    .illegal(illegal), .rs(rs), .rt(rt), .dest(dest), .shamt(shamt), .imm(imm), .hilo_busy(hilo_busy));

  always #5 clk = ~clk;
  assign sig = {alu_op, reg_wr_en, mem_wr_en, use_alu, pc_branch, pc_jump, i_type, j_type, r_type, illegal, rs, rt, dest, shamt, imm};

  // flags order: reg_wr, mem_wr, use_alu, branch, jump, i, j, r, illegal
  function automatic logic [64:0] mk(logic [31:0] ins, logic [3:0] a, logic [8:0] f, logic [4:0] d, logic [31:0] im);
    return {a, f, ins[25:21], ins[20:16], d, ins[10:6], im};
  endfunction

  task automatic chk(string tag, logic [64:0] got, logic [64:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // scoreboard: record accepted words, compare the head whenever it is consumed
  always @(negedge clk) begin
    if (reset || flush) q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $error("FAIL unexpected_pop observed=%h expected=none", sig);
        end else begin
          ent = q.pop_front();
          chk(ent.tag, sig, ent.e);
        end
      end
      if (in_valid && in_ready) q.push_back('{cur_exp, cur_tag});
    end
  end

  task automatic send(input string tag, input logic [31:0] ins, input logic [64:0] e, output int k);
    in_valid = 1'b1;
    instr = ins;
    cur_exp = e;
    cur_tag = tag;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({"accept_", tag}, 65'(in_ready), 65'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (!out_valid) break;
      @(posedge clk);
      #1;
    end
    chk("drain_valid", 65'(out_valid), 65'(0));
    chk("drain_scoreboard", 65'(q.size()), 65'(0));
    out_ready = 1'b0;
  endtask

  localparam logic [31:0] I_ADDU = 32'h00221821, I_MULT = 32'h00430018, I_MFLO = 32'h00001012;

  initial begin
    #100000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 65'(out_valid), 65'(0));
    chk("reset_hilo_busy", 65'(hilo_busy), 65'(0));
    reset = 1'b0;
    chk("release_in_ready", 65'(in_ready), 65'(1));
    // single ADDU into an empty FIFO: visible one edge later
    send("addu", I_ADDU, mk(I_ADDU, 4'b1010, 9'b101000010, 5'd3, 32'h00001821), waited);
    chk("addu_valid", 65'(out_valid), 65'(1));
    chk("addu_head", sig, mk(I_ADDU, 4'b1010, 9'b101000010, 5'd3, 32'h00001821));
    drain();
    // assorted patterns streamed with concurrent push and pop
    out_ready = 1'b1;
    send("addiu", 32'h2485FFFF, mk(32'h2485FFFF, 4'b1010, 9'b100001000, 5'd5, 32'hFFFFFFFF), waited);
    send("ori", 32'h34068001, mk(32'h34068001, 4'b0001, 9'b100001000, 5'd6, 32'h00008001), waited);
    send("lui", 32'h3C071234, mk(32'h3C071234, 4'b0000, 9'b100001000, 5'd7, 32'h12340000), waited);
    send("sw", 32'hAD280004, mk(32'hAD280004, 4'b0000, 9'b010001000, 5'd8, 32'h00000004), waited);
    send("bgezal", 32'h04710010, mk(32'h04710010, 4'b0011, 9'b000101000, 5'd31, 32'h00000010), waited);
    send("jal", 32'h0C000040, mk(32'h0C000040, 4'b0000, 9'b100010100, 5'd31, 32'h00000040), waited);
    send("jr", 32'h03E00008, mk(32'h03E00008, 4'b0000, 9'b001010010, 5'd0, 32'h00000008), waited);
    send("illegal", 32'hFC000000, mk(32'hFC000000, 4'b0000, 9'b000001001, 5'd0, 32'h00000000), waited);
    send("beq", 32'h10220003, mk(32'h10220003, 4'b0010, 9'b001101000, 5'd2, 32'h00000003), waited);
    send("sra", 32'h000521C3, mk(32'h000521C3, 4'b0110, 9'b101000010, 5'd4, 32'h000021C3), waited);
    drain();
    // HI/LO hazard: MFLO waits out the multiply latency
    out_ready = 1'b1;
    send("mult", I_MULT, mk(I_MULT, 4'b1110, 9'b001000010, 5'd0, 32'h00000018), waited);
    chk("mult_hilo_busy", 65'(hilo_busy), 65'(1));
    send("mflo", I_MFLO, mk(I_MFLO, 4'b0000, 9'b101000010, 5'd2, 32'h00001012), waited);
    chk("mflo_stall_cycles", 65'(waited), 65'(4));
    chk("mflo_hilo_idle", 65'(hilo_busy), 65'(0));
    drain();
    // fill to capacity, no bypass when full, then one pop admits the fifth
    for (int i = 1; i <= 4; i++)
      send($sformatf("fill%0d", i), 32'h24050000 | i, mk(32'h24050000 | i, 4'b1010, 9'b100001000, 5'd5, 32'(i)), waited);
    in_valid = 1'b1;
    instr = 32'h24050005;
    cur_exp = mk(32'h24050005, 4'b1010, 9'b100001000, 5'd5, 32'h5);
    cur_tag = "fill5";
    @(negedge clk);
    chk("full_in_ready", 65'(in_ready), 65'(0));
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_no_bypass", 65'(in_ready), 65'(0));
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("after_pop_in_ready", 65'(in_ready), 65'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();
    // flush with three buffered entries and a word offered
    send("fl_mult", I_MULT, mk(I_MULT, 4'b1110, 9'b001000010, 5'd0, 32'h18), waited);
    send("fl_a", 32'h24050011, mk(32'h24050011, 4'b1010, 9'b100001000, 5'd5, 32'h11), waited);
    send("fl_b", 32'h24050012, mk(32'h24050012, 4'b1010, 9'b100001000, 5'd5, 32'h12), waited);
    flush = 1'b1;
    in_valid = 1'b1;
    instr = 32'h24050013;
    cur_tag = "fl_c";
    @(negedge clk);
    chk("flush_in_ready", 65'(in_ready), 65'(0));
    chk("flush_hilo_before", 65'(hilo_busy), 65'(1));
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 65'(out_valid), 65'(0));
    chk("flush_hilo_after", 65'(hilo_busy), 65'(1));
    @(posedge clk);
    #1 chk("flush_no_push", 65'(out_valid), 65'(0));
    repeat (3) @(posedge clk);
    #1;
    // asynchronous reset with two entries and a busy multiplier
    send("rs_mult", I_MULT, mk(I_MULT, 4'b1110, 9'b001000010, 5'd0, 32'h18), waited);
    send("rs_addu", I_ADDU, mk(I_ADDU, 4'b1010, 9'b101000010, 5'd3, 32'h1821), waited);
    chk("pre_reset_valid", 65'(out_valid), 65'(1));
    chk("pre_reset_busy", 65'(hilo_busy), 65'(1));
    #2 reset = 1'b1;
    #1;
    chk("async_reset_valid", 65'(out_valid), 65'(0));
    chk("async_reset_busy", 65'(hilo_busy), 65'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    chk("post_reset_in_ready", 65'(in_ready), 65'(1));
    chk("post_reset_valid", 65'(out_valid), 65'(0));
    out_ready = 1'b1;
    send("recover", I_ADDU, mk(I_ADDU, 4'b1010, 9'b101000010, 5'd3, 32'h1821), waited);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/instruction_decode_pipe.md
INSTRUCTION_DECODE_PIPE -- requirements
Module: instruction_decode_pipe

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered decoded entries (power of 2, >=2).
REQ-002 SHALL have parameter MULDIV_CYCLES, default 32, HI/LO busy cycles after a MULT/MULTU/DIV/DIVU issue (>=1).
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports in_valid in 1, in_ready out 1, instr in 32: fetch handshake.
REQ-006 SHALL have port flush  in  1  discard all buffered entries (taken branch/jump).
REQ-007 SHALL have ports out_valid out 1, out_ready in 1: execute handshake.
REQ-008 SHALL have outputs alu_op 4; reg_wr_en, mem_wr_en, use_alu, pc_branch, pc_jump, i_type, j_type, r_type, illegal 1 each; rs, rt, dest 5 each; shamt 5; imm 32; hilo_busy 1.

Function
REQ-009 SHALL decode alu_op: R-type fn SLL/SLLV 0101, SRL/SRLV 0111, SRA/SRAV 0110, MULT 1110, MULTU 1111, DIV 1100, DIVU 1101, ADDU 1010, SUBU 1011, AND 0000, OR 0001, XOR 0010, SLT 1000, SLTU 1001; opcode 000001 0011, 00010x 0010, 00011x 0100, ADDIU 1010, SLTI 1000, SLTIU 1001, ANDI 0000, ORI 0001, XORI 0010; all others 0000 (never X/Z).
REQ-010 SHALL decode r_type = op 000000; j_type = op 00001x; i_type = neither; pc_branch = op 000001 or 0001xx; pc_jump = JR/JALR or J/JAL; use_alu = ~op[0]; mem_wr_en = op 101xxx.
REQ-011 SHALL set reg_wr_en=0 for MULT/MULTU/DIV/DIVU, MTHI/MTLO, JR, stores, branches, J; 1 otherwise.
REQ-012 SHALL set dest = rd for R-type, 31 for JAL and BGEZAL/BLTZAL, rt otherwise.
REQ-013 SHALL sign-extend instr[15:0] to imm, except ANDI/ORI/XORI zero-extend and LUI shifts left 16.
REQ-014 SHALL assert illegal for opcodes/fn codes outside the supported set; illegal entries SHALL still flow with reg_wr_en=mem_wr_en=0.
REQ-015 SHALL push on in_valid&in_ready; pop on out_valid&out_ready; out_valid = FIFO non-empty; outputs from head entry.
REQ-016 SHALL give latency one cycle: entry pushed at edge N visible at out_* after edge N when FIFO was empty.
REQ-017 SHALL set in_ready = ~full & ~flush & ~stall; no full-bypass (push when full rejected even with simultaneous pop).
REQ-018 SHALL push and pop in the same cycle when not full and not empty, count unchanged.
REQ-019 SHALL load busy counter with MULDIV_CYCLES on pushing MULT/MULTU/DIV/DIVU, else decrement to 0 and hold; hilo_busy = counter!=0.
REQ-020 SHALL stall = hilo_busy & instr is MFHI/MFLO/MTHI/MTLO/MULT/MULTU/DIV/DIVU.
REQ-021 SHALL on flush empty FIFO next edge (pointers and count to 0), ignore same-cycle push/pop; busy counter unaffected (conservative).
REQ-022 SHALL wrap read/write pointers modulo FIFO_DEPTH.

Reset
REQ-023 SHALL on reset asynchronously clear pointers, count, busy counter; out_valid=0, hilo_busy=0, in_ready=1 after release.
REQ-024 SHALL discard buffered entries when reset asserts mid-operation; FIFO storage need not be cleared.

Structure
REQ-025 SHALL place alu_op encodings, opcode/fn constants and the decoded-entry struct in package decode_pkg.
REQ-026 SHALL instantiate combinational sub-module decode_fields (instr -> decoded entry) ahead of the FIFO.

Verification
REQ-027 ADDU 0x00221821 pushed to empty FIFO -> next cycle out_valid=1, alu_op=1010, reg_wr_en=1, r_type=1, dest=3.
REQ-028 MULT 0x00430018 then MFLO 0x00001012, MULDIV_CYCLES=4 -> in_ready low 4 cycles for MFLO, accepted on 5th.
REQ-029 out_ready=0, 5 back-to-back ADDIU -> 4 accepted, in_ready=0; one pop -> 5th accepted next cycle, order preserved.
REQ-030 3 buffered entries, flush with in_valid=1 -> next cycle out_valid=0, no push, hilo_busy unchanged.
REQ-031 Opcode 0x3F instruction -> illegal=1, reg_wr_en=0, mem_wr_en=0, alu_op=0000.
REQ-032 Reset asserted mid-stream with 2 entries, hilo_busy=1 -> out_valid=0, hilo_busy=0 immediately, in_ready=1 after release.
